branch_pc_unit: RTL and testbench

//  - Program-counter stage directly downstream of the CON FF branch-condition logic.
//  - Holds the PC and applies an optional conditional-branch offset.
//  - Captures the branch offset from IR at branch start, waits for the CON FF result
//    (taken/not-taken), then commits PC <= PC + sext(offset) or leaves the PC unchanged.
//  - Sits between the control unit / CON FF and the PC register feeding MAR/bus.

---
 rtl/branch_pc_unit.sv | 114 +++++++++++
 tb/tb_branch_pc_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter with conditional relative branch resolved by the CON FF result.
// Optional BR_STATS_EN adds saturating committed/taken branch counters.
module branch_pc_unit #(
  parameter int              PC_W     = 32,
  parameter int              OFF_W    = 19,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            pc_load,
  input  logic [PC_W-1:0] bus_in,
  input  logic            inc_pc,
  input  logic            br_start,
  input  logic            con_valid,
  input  logic            con_branch,
  output logic [PC_W-1:0] pc_out,
  output logic            busy,
  output logic            br_done,
  output logic            br_taken
`ifdef BR_STATS_EN
  ,
  output logic [15:0]     br_count,
  output logic [15:0]     br_taken_count
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_CON, UPDATE} state_t;

  state_t                 state, state_nxt;
  logic [PC_W-1:0]        pc_r;
  logic signed [PC_W-1:0] off_r;
  logic                   taken_r;
  logic                   off_ld, taken_ld, commit;
  logic                   unused_ir;

  assign unused_ir = ^ir[31:OFF_W];

  function automatic logic signed [PC_W-1:0] sext_off(input logic [OFF_W-1:0] f);
    return {{(PC_W-OFF_W){f[OFF_W-1]}}, f};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // A pc_load while a branch is pending abandons it without a commit.
  always_comb begin
    state_nxt = state;
    off_ld    = 1'b0;
    taken_ld  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (br_start) begin
          off_ld    = 1'b1;
          state_nxt = WAIT_CON;
        end
      end
      WAIT_CON: begin
        if (pc_load) begin
          state_nxt = IDLE;
        end else if (con_valid) begin
          taken_ld  = 1'b1;
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        state_nxt = IDLE;
        commit    = !pc_load;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign br_done = commit;
  assign pc_out  = pc_r;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_r     <= RESET_PC;
      off_r    <= '0;
      taken_r  <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      if (off_ld)   off_r   <= sext_off(ir[OFF_W-1:0]);
      if (taken_ld) taken_r <= con_branch;
      if (commit)   br_taken <= taken_r;
      // Load beats a taken branch, which beats increment.
      if (pc_load)                pc_r <= bus_in;
      else if (commit && taken_r) pc_r <= pc_r + $unsigned(off_r);
      else if (inc_pc)            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else if (commit) begin
      br_count <= sat_inc(br_count);
      if (taken_r) br_taken_count <= sat_inc(br_taken_count);
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit (define BR_STATS_EN to cover the counters).
module tb_branch_pc_unit;

  logic        clk, clr;
  logic [31:0] ir, bus_in, pc_out;
  logic        pc_load, inc_pc, br_start, con_valid, con_branch;
  logic        busy, br_done, br_taken;
`ifdef BR_STATS_EN
  logic [15:0] br_count, br_taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  branch_pc_unit #(.PC_W(32), .OFF_W(19), .RESET_PC(32'h0)) dut (
    .clk(clk), .clr(clr), .ir(ir), .pc_load(pc_load), .bus_in(bus_in),
    .inc_pc(inc_pc), .br_start(br_start), .con_valid(con_valid),
    .con_branch(con_branch), .pc_out(pc_out), .busy(busy),
    .br_done(br_done), .br_taken(br_taken)
`ifdef BR_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load = 1'b1; bus_in = v;
    tick();
    pc_load = 1'b0;
  endtask

  // br_start, CON result next cycle, commit cycle; returns one cycle after commit.
  task automatic branch(input logic [31:0] irv, input logic tk);
    ir = irv; br_start = 1'b1;
    tick();
    br_start = 1'b0; con_valid = 1'b1; con_branch = tk;
    tick();
    con_valid = 1'b0; con_branch = 1'b0;
    chk("br_done_commit", {31'b0, br_done}, 32'h1);
    tick();
    chk("br_done_pulse_end", {31'b0, br_done}, 32'h0);
  endtask

  initial begin
    clr = 1'b0; ir = '0; bus_in = '0; pc_load = 0; inc_pc = 0;
    br_start = 0; con_valid = 0; con_branch = 0;
    #3;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_taken", {31'b0, br_taken}, 32'h0);
    chk("reset_done", {31'b0, br_done}, 32'h0);
    #20 clr = 1'b1;
    tick();
    inc_pc = 1'b1;
    tick(); tick(); tick();
    inc_pc = 1'b0;
    chk("inc3", pc_out, 32'h3);

    // Taken forward with latency checks
    load_pc(32'h10);
    ir = 32'h5; br_start = 1'b1;
    tick();
    br_start = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'h1);
    chk("wait_no_done", {31'b0, br_done}, 32'h0);
    con_valid = 1'b1; con_branch = 1'b1;
    tick();
    con_valid = 1'b0; con_branch = 1'b0;
    chk("update_done", {31'b0, br_done}, 32'h1);
    chk("update_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("fwd_pc", pc_out, 32'h15);
    chk("fwd_taken", {31'b0, br_taken}, 32'h1);
    chk("fwd_idle", {31'b0, busy}, 32'h0);

    // Taken backward, then not taken
    load_pc(32'h10);
    branch(32'h7FFFE, 1'b1);
    chk("back_pc", pc_out, 32'hE);
    branch(32'h5, 1'b0);
    chk("nt_pc", pc_out, 32'hE);
    chk("nt_taken", {31'b0, br_taken}, 32'h0);

    // Taken update beats coincident inc_pc
    load_pc(32'h20);
    ir = 32'h4; br_start = 1'b1;
    tick();
    br_start = 1'b0; con_valid = 1'b1; con_branch = 1'b1;
    tick();
    con_valid = 1'b0; con_branch = 1'b0; inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0;
    chk("prio_pc", pc_out, 32'h24);

    // pc_load aborts in WAIT_CON; later con_valid ignored
    ir = 32'h8; br_start = 1'b1;
    tick();
    br_start = 1'b0; pc_load = 1'b1; bus_in = 32'h100;
    tick();
    pc_load = 1'b0;
    chk("abort_pc", pc_out, 32'h100);
    chk("abort_idle", {31'b0, busy}, 32'h0);
    chk("abort_taken_kept", {31'b0, br_taken}, 32'h1);
    con_valid = 1'b1; con_branch = 1'b1;
    chk("abort_no_done", {31'b0, br_done}, 32'h0);
    tick();
    con_valid = 1'b0; con_branch = 1'b0;
    chk("stray_con_busy", {31'b0, busy}, 32'h0);
    chk("stray_con_pc", pc_out, 32'h100);

    // inc_pc in WAIT_CON and in not-taken UPDATE
    load_pc(32'h30);
    ir = 32'h2; br_start = 1'b1;
    tick();
    br_start = 1'b0; inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0;
    chk("inc_wait_pc", pc_out, 32'h31);
    con_valid = 1'b1; con_branch = 1'b0;
    tick();
    con_valid = 1'b0; inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0;
    chk("inc_nt_update_pc", pc_out, 32'h32);

    // con_valid with br_start ignored; second br_start does not re-latch
    load_pc(32'h40);
    ir = 32'h3; br_start = 1'b1; con_valid = 1'b1; con_branch = 1'b1;
    tick();
    br_start = 1'b0; con_valid = 1'b0; con_branch = 1'b0;
    tick();
    chk("same_cycle_con_busy", {31'b0, busy}, 32'h1);
    chk("same_cycle_con_pc", pc_out, 32'h40);
    ir = 32'h10; br_start = 1'b1; con_valid = 1'b1; con_branch = 1'b1;
    tick();
    br_start = 1'b0; con_valid = 1'b0; con_branch = 1'b0;
    tick();
    chk("no_relatch_pc", pc_out, 32'h43);

    // Wrap-around
    load_pc(32'hFFFFFFFF);
    inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0;
    chk("wrap_inc", pc_out, 32'h0);
    load_pc(32'hFFFFFFFE);
    branch(32'h3, 1'b1);
    chk("wrap_branch", pc_out, 32'h1);
    load_pc(32'h0);
    branch(32'h7FFFF, 1'b1);
    chk("neg_one_branch", pc_out, 32'hFFFFFFFF);

    // Async reset while waiting on CON
    load_pc(32'h50);
    ir = 32'h6; br_start = 1'b1;
    tick();
    br_start = 1'b0;
    #2 clr = 1'b0;
    #1;
    chk("areset_pc", pc_out, 32'h0);
    chk("areset_busy", {31'b0, busy}, 32'h0);
    chk("areset_taken", {31'b0, br_taken}, 32'h0);
    #2 clr = 1'b1;
    tick();
    con_valid = 1'b1; con_branch = 1'b1;
    tick();
    con_valid = 1'b0; con_branch = 1'b0;
    chk("post_reset_no_done", {31'b0, br_done}, 32'h0);
    tick();
    chk("post_reset_pc", pc_out, 32'h0);

`ifdef BR_STATS_EN
    chk("stats_reset_cnt", {16'b0, br_count}, 32'h0);
    chk("stats_reset_tcnt", {16'b0, br_taken_count}, 32'h0);
    branch(32'h1, 1'b1);
    branch(32'h1, 1'b0);
    ir = 32'h9; br_start = 1'b1;
    tick();
    br_start = 1'b0; pc_load = 1'b1; bus_in = 32'h0;
    tick();
    pc_load = 1'b0;
    branch(32'h1, 1'b1);
    chk("stats_cnt", {16'b0, br_count}, 32'h3);
    chk("stats_tcnt", {16'b0, br_taken_count}, 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
